// File: rtl/calc_pkg.sv
// calc_pkg: shared state type, operation indices and BCD helpers for the result path
package calc_pkg;

    typedef enum logic [2:0] {IDLE, WAIT_OP, LATCH, CONVERT, DONE} state_t;

    localparam int SIN          = 0;
    localparam int COS          = 1;
    localparam int IS_PRIME     = 2;
    localparam int SQUARE       = 3;
    localparam int NO_OPERATION = 4;

    function automatic int bcd_max(input int n);
        int m = 1;
        for (int i = 0; i < n; i++) m = m * 10;
        return m - 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble, one shift per cycle for OUT_W cycles
module bin_to_bcd_seq #(
    parameter int OUT_W      = 14,
    parameter int BCD_DIGITS = 4
) (
    input  logic                    clk_fpga_100mhz,
    input  logic                    reset,
    input  logic                    load,
    input  logic [OUT_W-1:0]        bin,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);
    localparam int BW = 4 * BCD_DIGITS;
    localparam int CW = $clog2(OUT_W + 1);

    logic [BW+OUT_W-1:0] sr, sr_nx;
    logic [BW-1:0]       adj;
    logic [CW-1:0]       cnt;

    // Correct every digit that would overflow on doubling, then shift once
    always_comb begin
        adj = '0;
        for (int d = 0; d < BCD_DIGITS; d++)
            adj[4*d +: 4] = (sr[OUT_W+4*d +: 4] >= 4'd5) ? sr[OUT_W+4*d +: 4] + 4'd3 : sr[OUT_W+4*d +: 4];
        sr_nx = {adj, sr[OUT_W-1:0]} << 1;
    end

    assign done = (cnt == CW'(1));
    assign bcd  = sr_nx[OUT_W +: BW];

    // Shift register and step counter; load restarts a conversion
    always_ff @(posedge clk_fpga_100mhz or negedge reset) begin
        if (!reset) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= {{BW{1'b0}}, bin};
            cnt <= CW'(OUT_W);
        end else if (cnt != '0) begin
            sr  <= sr_nx;
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/result_capture_unit.sv
// result_capture_unit: selects an operation result, saturates it and converts it to BCD for display
module result_capture_unit
    import calc_pkg::*;
#(
    parameter int NUM_OPS        = 5,
    parameter int WHOLE_W        = 7,
    parameter int FRAC_W         = 7,
    parameter int SCALE          = 100,
    parameter int BCD_DIGITS     = 4,
    parameter int OUT_W          = 14,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk_fpga_100mhz,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(NUM_OPS)-1:0] op_sel,
    input  logic [NUM_OPS-1:0]         op_valid,
    input  logic [NUM_OPS*WHOLE_W-1:0] whole_in,
    input  logic [NUM_OPS*FRAC_W-1:0]  frac_in,
    input  logic [NUM_OPS-1:0]         sign_in,
    output logic                       busy,
    output logic                       result_valid,
    output logic [OUT_W-1:0]           result_bin,
    output logic [4*BCD_DIGITS-1:0]    result_bcd,
    output logic                       result_sign,
    output logic                       overflow,
    output logic                       error
);
    localparam int SW   = $clog2(NUM_OPS);
    localparam int VW   = WHOLE_W + $clog2(SCALE) + 1;
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int VMAX = bcd_max(BCD_DIGITS);

    state_t                  state, state_nx;
    logic [SW-1:0]           sel;
    logic [TW-1:0]           tcnt;
    logic [WHOLE_W-1:0]      w;
    logic [FRAC_W-1:0]       fr, f;
    logic [VW-1:0]           v;
    logic [OUT_W-1:0]        v_res;
    logic                    fclamp, vsat, bad_op, timeout, conv_done;
    logic [4*BCD_DIGITS-1:0] conv_bcd;

    assign w       = whole_in[32'(sel)*WHOLE_W +: WHOLE_W];
    assign fr      = frac_in[32'(sel)*FRAC_W +: FRAC_W];
    assign fclamp  = 32'(fr) > SCALE - 1;
    assign f       = fclamp ? FRAC_W'(SCALE - 1) : fr;
    assign v       = VW'(w) * VW'(SCALE) + VW'(f);
    assign vsat    = 32'(v) > VMAX;
    assign v_res   = vsat ? OUT_W'(VMAX) : OUT_W'(v);
    assign bad_op  = 32'(op_sel) >= NUM_OPS;
    assign timeout = tcnt == TW'(TIMEOUT_CYCLES - 1);

    assign busy         = (state == WAIT_OP) || (state == LATCH) || (state == CONVERT);
    assign result_valid = (state == DONE);

    bin_to_bcd_seq #(.OUT_W(OUT_W), .BCD_DIGITS(BCD_DIGITS)) u_bcd (
        .clk_fpga_100mhz (clk_fpga_100mhz),
        .reset           (reset),
        .load            (state == LATCH),
        .bin             (v_res),
        .done            (conv_done),
        .bcd             (conv_bcd)
    );

    // State register
    always_ff @(posedge clk_fpga_100mhz or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state; start is only honoured while idle or presenting a result
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = bad_op ? DONE : WAIT_OP;
            WAIT_OP:    state_nx = op_valid[sel] ? LATCH : timeout ? DONE : WAIT_OP;
            LATCH:      state_nx = CONVERT;
            CONVERT:    state_nx = conv_done ? DONE : CONVERT;
            default:    state_nx = IDLE;
        endcase
    end

    // Result registers: capture selection, saturate on LATCH, take BCD when conversion ends
    always_ff @(posedge clk_fpga_100mhz or negedge reset) begin
        if (!reset) begin
            sel         <= '0;
            tcnt        <= '0;
            result_bin  <= '0;
            result_bcd  <= '0;
            result_sign <= 1'b0;
            overflow    <= 1'b0;
            error       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    sel      <= op_sel;
                    tcnt     <= '0;
                    overflow <= 1'b0;
                    error    <= bad_op;
                    if (bad_op) begin
                        result_bin  <= '0;
                        result_bcd  <= '0;
                        result_sign <= 1'b0;
                    end
                end
                WAIT_OP: if (!op_valid[sel]) begin
                    tcnt <= tcnt + 1'b1;
                    if (timeout) begin
                        result_bin  <= '0;
                        result_bcd  <= '0;
                        result_sign <= 1'b0;
                        error       <= 1'b1;
                    end
                end
                LATCH: begin
                    result_bin  <= v_res;
                    result_sign <= sign_in[sel] & (v_res != '0);
                    overflow    <= fclamp | vsat;
                end
                CONVERT: if (conv_done) result_bcd <= conv_bcd;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_result_capture_unit.sv
// tb_result_capture_unit: vector table, directed corner sequences and randomized checks against a reference model
module tb_result_capture_unit;

    localparam int N  = 5;
    localparam int WW = 7;
    localparam int FW = 7;
    localparam int TO = 1024;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op_sel = '0;
    logic [N-1:0]  op_valid = '0;
    logic [N*WW-1:0] whole_in = '0;
    logic [N*FW-1:0] frac_in = '0;
    logic [N-1:0]  sign_in = '0;
    logic          busy, result_valid, result_sign, overflow, error;
    logic [13:0]   result_bin;
    logic [15:0]   result_bcd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int op, w, f, s;
        int eb, ebcd, es, eo, ee, lat;
    } vec_t;

    vec_t vt[12];

    result_capture_unit dut (
        .clk_fpga_100mhz (clk),
        .reset           (reset),
        .start           (start),
        .op_sel          (op_sel),
        .op_valid        (op_valid),
        .whole_in        (whole_in),
        .frac_in         (frac_in),
        .sign_in         (sign_in),
        .busy            (busy),
        .result_valid    (result_valid),
        .result_bin      (result_bin),
        .result_bcd      (result_bcd),
        .result_sign     (result_sign),
        .overflow        (overflow),
        .error           (error)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int eb, input int ebcd, input int es, input int eo, input int ee);
        check({tag, ".valid"}, 32'(result_valid), 1);
        check({tag, ".bin"}, 32'(result_bin), eb);
        check({tag, ".bcd"}, 32'(result_bcd), ebcd);
        check({tag, ".sign"}, 32'(result_sign), es);
        check({tag, ".ovf"}, 32'(overflow), eo);
        check({tag, ".err"}, 32'(error), ee);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".valid"}, 32'(result_valid), 0);
        check({tag, ".bin"}, 32'(result_bin), 0);
        check({tag, ".bcd"}, 32'(result_bcd), 0);
        check({tag, ".sign"}, 32'(result_sign), 0);
        check({tag, ".ovf"}, 32'(overflow), 0);
        check({tag, ".err"}, 32'(error), 0);
    endtask

    task automatic set_ch(input int ch, input int w, input int f, input int s);
        whole_in[ch*WW +: WW] = WW'(w);
        frac_in[ch*FW +: FW]  = FW'(f);
        sign_in[ch]           = s[0];
    endtask

    task automatic pulse_start(input int op);
        tick();
        op_sel = 3'(op);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int bound, inout int cyc, inout int busy_n);
        while (!result_valid && cyc < bound) begin
            busy_n += int'(busy);
            tick();
            cyc++;
        end
    endtask

    // Start an operation; optionally raise the selected channel's valid at cycle valid_at
    task automatic run(input int op, input int valid_at, input int bound, output int lat, output int busy_n);
        pulse_start(op);
        lat = 1;
        busy_n = 0;
        while (!result_valid && lat < bound) begin
            if (lat == valid_at && op < N) op_valid[op] = 1'b1;
            busy_n += int'(busy);
            tick();
            lat++;
        end
    endtask

    // Reference: expected display value from the selection rules, digits by decimal arithmetic
    task automatic model(input int op, input int w, input int f, input int s,
                         output int eb, output int ebcd, output int es, output int eo, output int ee, output int lat);
        int ff, v;
        if (op >= N) begin
            eb = 0; ebcd = 0; es = 0; eo = 0; ee = 1; lat = 1;
        end else begin
            ff = (f > 99) ? 99 : f;
            eo = (f > 99) ? 1 : 0;
            v  = w * 100 + ff;
            if (v > 9999) begin
                v  = 9999;
                eo = 1;
            end
            eb   = v;
            ebcd = ((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
            es   = (s != 0 && v != 0) ? 1 : 0;
            ee   = 0;
            lat  = 17;
        end
    endtask

    initial begin
        int lat, bn, cyc;
        int eb, ebcd, es, eo, ee, el;
        int op, w, f, s;
        int ws[N], fs[N], ss[N];

        vt[0]  = '{0, 0,   87,  1, 87,   'h0087, 1, 0, 0, 17};
        vt[1]  = '{3, 99,  99,  0, 9999, 'h9999, 0, 0, 0, 17};
        vt[2]  = '{3, 127, 99,  0, 9999, 'h9999, 0, 1, 0, 17};
        vt[3]  = '{6, 0,   0,   0, 0,    'h0000, 0, 0, 1, 1};
        vt[4]  = '{4, 0,   0,   0, 0,    'h0000, 0, 0, 0, 17};
        vt[5]  = '{1, 1,   127, 0, 199,  'h0199, 0, 1, 0, 17};
        vt[6]  = '{2, 0,   0,   1, 0,    'h0000, 0, 0, 0, 17};
        vt[7]  = '{1, 12,  5,   1, 1205, 'h1205, 1, 0, 0, 17};
        vt[8]  = '{7, 0,   0,   0, 0,    'h0000, 0, 0, 1, 1};
        vt[9]  = '{0, 0,   100, 0, 99,   'h0099, 0, 1, 0, 17};
        vt[10] = '{3, 100, 0,   0, 9999, 'h9999, 0, 1, 0, 17};
        vt[11] = '{3, 99,  100, 1, 9999, 'h9999, 1, 1, 0, 17};

        #3;
        check_zero("reset");
        tick();
        reset = 1'b1;
        tick();
        check_zero("post_reset");

        for (int i = 0; i < 12; i++) begin
            op_valid = '1;
            whole_in = '0;
            frac_in  = '0;
            sign_in  = '0;
            if (vt[i].op < N) set_ch(vt[i].op, vt[i].w, vt[i].f, vt[i].s);
            run(vt[i].op, 0, 100, lat, bn);
            check($sformatf("vec%0d.lat", i), lat, vt[i].lat);
            check_out($sformatf("vec%0d", i), vt[i].eb, vt[i].ebcd, vt[i].es, vt[i].eo, vt[i].ee);
        end

        op_valid = 5'b11011;
        set_ch(2, 45, 67, 1);
        run(2, 0, 2000, lat, bn);
        check("timeout.lat", lat, TO + 1);
        check("timeout.busy_cycles", bn, TO);
        check_out("timeout", 0, 0, 0, 0, 1);

        run(2, 11, 200, lat, bn);
        check("late_valid.lat", lat, 27);
        check("late_valid.busy_cycles", bn, 26);
        check_out("late_valid", 4567, 'h4567, 1, 0, 0);

        op_valid = '1;
        set_ch(1, 12, 34, 0);
        pulse_start(1);
        cyc = 1;
        bn = 0;
        repeat (4) begin
            tick();
            cyc++;
        end
        op_sel   = 3'd6;
        start    = 1'b1;
        whole_in = '1;
        frac_in  = '1;
        sign_in  = '1;
        op_valid = '0;
        tick();
        cyc++;
        start = 1'b0;
        wait_done(60, cyc, bn);
        check("ignored_start.lat", cyc, 17);
        check_out("ignored_start", 1234, 'h1234, 0, 0, 0);

        op_valid = '1;
        whole_in = '0;
        frac_in  = '0;
        sign_in  = '0;
        set_ch(0, 0, 5, 0);
        pulse_start(0);
        check("done_start.valid", 32'(result_valid), 0);
        check("done_start.busy", 32'(busy), 1);
        cyc = 1;
        wait_done(60, cyc, bn);
        check("done_start.lat", cyc, 17);
        check_out("done_start", 5, 'h0005, 0, 0, 0);

        set_ch(3, 50, 5, 1);
        pulse_start(3);
        repeat (6) tick();
        check("pre_reset.busy", 32'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        tick();
        tick();
        reset = 1'b1;
        repeat (20) tick();
        check_zero("after_reset");

        set_ch(1, 1, 150 - 128 + 128 > 127 ? 127 : 150, 0);
        run(1, 0, 100, lat, bn);
        check("fresh.lat", lat, 17);
        check_out("fresh", 199, 'h0199, 0, 1, 0);

        for (int i = 0; i < 30; i++) begin
            op_valid = '1;
            for (int c = 0; c < N; c++) begin
                ws[c] = (i % 2 == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 127));
                fs[c] = int'($urandom_range(0, 127));
                ss[c] = int'($urandom_range(0, 1));
                set_ch(c, ws[c], fs[c], ss[c]);
            end
            op = int'($urandom_range(0, 7));
            w  = (op < N) ? ws[op] : 0;
            f  = (op < N) ? fs[op] : 0;
            s  = (op < N) ? ss[op] : 0;
            model(op, w, f, s, eb, ebcd, es, eo, ee, el);
            run(op, 0, 100, lat, bn);
            check($sformatf("rand%0d.lat", i), lat, el);
            check_out($sformatf("rand%0d", i), eb, ebcd, es, eo, ee);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
